ret_stack: RTL and testbench

RET_STACK -- requirements
Module: ret_stack

---
 rtl/ret_stack_pkg.sv | 22 ++
 rtl/ret_stack_mem.sv | 26 ++
 rtl/ret_stack.sv | 98 +++++++++
 tb/tb_ret_stack.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ret_stack_pkg.sv
// Shared constants, count-width helper and operation decode type for the return stack.
package ret_stack_pkg;

  localparam int PC_WIDTH    = 10;
  localparam int STACK_DEPTH = 8;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef enum logic [2:0] {
    OP_IDLE,
    OP_FLUSH,
    OP_PUSH,
    OP_PUSH_OVF,
    OP_POP,
    OP_POP_UNF,
    OP_REPLACE,
    OP_PUSH_UNF
  } stack_op_t;

endpackage

// File: rtl/ret_stack_mem.sv
// Return-stack storage: DEPTH x WIDTH, one synchronous write port, one combinational read port.
module ret_stack_mem #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  // Contents are never reset; they are only visible through valid stack slots.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ret_stack.sv
// Return-address LIFO: pointer, sticky error flags and push/pop/flush decode around ret_stack_mem.
module ret_stack
  import ret_stack_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter int DEPTH = STACK_DEPTH,
  localparam int CW   = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic             clr_err,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count,
  output logic             ovf,
  output logic             unf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CW-1:0]    sp_reg, sp_next;
  logic             ovf_reg, ovf_next;
  logic             unf_reg, unf_next;
  stack_op_t        op;
  logic             we;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] rdata;

  assign empty = (sp_reg == '0);
  assign full  = (sp_reg == CW'(DEPTH));
  assign count = sp_reg;
  assign ovf   = ovf_reg;
  assign unf   = unf_reg;

  // Both indices are forced in range even when the stack is empty or full.
  assign top_idx = empty ? '0 : AW'(sp_reg - CW'(1));
  assign waddr   = (op == OP_REPLACE) ? top_idx : (full ? '0 : AW'(sp_reg));
  assign we      = (op == OP_PUSH) || (op == OP_REPLACE) || (op == OP_PUSH_UNF);
  assign dout    = empty ? '0 : rdata;

  always_comb begin
    op = OP_IDLE;
    if (flush) begin
      op = OP_FLUSH;
    end else if (push && pop) begin
      op = empty ? OP_PUSH_UNF : OP_REPLACE;
    end else if (push) begin
      op = full ? OP_PUSH_OVF : OP_PUSH;
    end else if (pop) begin
      op = empty ? OP_POP_UNF : OP_POP;
    end
  end

  always_comb begin
    sp_next = sp_reg;
    case (op)
      OP_PUSH, OP_PUSH_UNF: sp_next = sp_reg + CW'(1);
      OP_POP:               sp_next = sp_reg - CW'(1);
      OP_FLUSH:             sp_next = '0;
      default:              sp_next = sp_reg;
    endcase
  end

  // A new error in the same cycle as clr_err leaves its flag set.
  assign ovf_next = (ovf_reg & ~clr_err) | (op == OP_PUSH_OVF);
  assign unf_next = (unf_reg & ~clr_err) | (op == OP_POP_UNF) | (op == OP_PUSH_UNF);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_reg  <= '0;
      ovf_reg <= 1'b0;
      unf_reg <= 1'b0;
    end else begin
      sp_reg  <= sp_next;
      ovf_reg <= ovf_next;
      unf_reg <= unf_next;
    end
  end

  ret_stack_mem #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_mem (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(din),
    .raddr(top_idx),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_ret_stack.sv
// Directed self-checking bench for ret_stack with default WIDTH=10, DEPTH=8.
module tb_ret_stack;

  logic       clk;
  logic       reset;
  logic       push;
  logic       pop;
  logic       flush;
  logic       clr_err;
  logic [9:0] din;
  logic [9:0] dout;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       ovf;
  logic       unf;

  int errors = 0;
  int checks = 0;

  ret_stack dut (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .pop    (pop),
    .flush  (flush),
    .clr_err(clr_err),
    .din    (din),
    .dout   (dout),
    .empty  (empty),
    .full   (full),
    .count  (count),
    .ovf    (ovf),
    .unf    (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one cycle of inputs, lets the edge happen, and samples 1 time unit later.
  task automatic cycle(input logic p, input logic po, input logic f, input logic c,
                       input logic [9:0] d);
    push = p; pop = po; flush = f; clr_err = c; din = d;
    @(posedge clk); #1;
    push = 1'b0; pop = 1'b0; flush = 1'b0; clr_err = 1'b0;
    $display("txn push=%0b pop=%0b flush=%0b clr=%0b din=%03h -> count=%0d dout=%03h ovf=%0b unf=%0b",
             p, po, f, c, d, count, dout, ovf, unf);
  endtask

  task automatic test_reset();
    reset = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0; clr_err = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%0b exp=1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%0b exp=0", full); end
    checks++; if (dout !== 10'h000) begin errors++; $display("FAIL reset_dout got=%03h exp=000", dout); end
    checks++; if ({ovf, unf} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%02b exp=00", {ovf, unf}); end
    reset = 1'b0;
    // First push after release must land on the very first edge.
    cycle(1, 0, 0, 0, 10'h005);
    checks++; if (count !== 4'd1 || dout !== 10'h005) begin
      errors++; $display("FAIL first_push got count=%0d dout=%03h exp count=1 dout=005", count, dout);
    end
    cycle(0, 1, 0, 0, 10'h000);
  endtask

  task automatic test_push_pop();
    cycle(1, 0, 0, 0, 10'h005);
    cycle(1, 0, 0, 0, 10'h1A3);
    cycle(1, 0, 0, 0, 10'h3FF);
    checks++; if (count !== 4'd3 || dout !== 10'h3FF) begin
      errors++; $display("FAIL push3 got count=%0d dout=%03h exp count=3 dout=3FF", count, dout);
    end
    cycle(0, 1, 0, 0, 10'h000);
    checks++; if (dout !== 10'h1A3) begin errors++; $display("FAIL pop1 got=%03h exp=1A3", dout); end
    cycle(0, 1, 0, 0, 10'h000);
    checks++; if (dout !== 10'h005) begin errors++; $display("FAIL pop2 got=%03h exp=005", dout); end
    cycle(0, 1, 0, 0, 10'h000);
    checks++; if (dout !== 10'h000) begin errors++; $display("FAIL pop3 got=%03h exp=000", dout); end
    checks++; if (empty !== 1'b1 || unf !== 1'b0) begin
      errors++; $display("FAIL pop_end got empty=%0b unf=%0b exp empty=1 unf=0", empty, unf);
    end
  endtask

  task automatic test_overflow();
    logic [9:0] v;
    for (int i = 0; i < 8; i++) begin
      v = 10'h010 + 10'(i);
      cycle(1, 0, 0, 0, v);
    end
    checks++; if (full !== 1'b1 || count !== 4'd8 || ovf !== 1'b0) begin
      errors++; $display("FAIL fill8 got full=%0b count=%0d ovf=%0b exp full=1 count=8 ovf=0", full, count, ovf);
    end
    cycle(1, 0, 0, 0, 10'h2AA);
    checks++; if (full !== 1'b1 || count !== 4'd8 || dout !== 10'h017 || ovf !== 1'b1) begin
      errors++; $display("FAIL push_full got full=%0b count=%0d dout=%03h ovf=%0b exp full=1 count=8 dout=017 ovf=1",
                         full, count, dout, ovf);
    end
    for (int i = 0; i < 8; i++) begin
      v = 10'h017 - 10'(i);
      checks++; if (dout !== v) begin errors++; $display("FAIL lifo_order[%0d] got=%03h exp=%03h", i, dout, v); end
      cycle(0, 1, 0, 0, 10'h000);
    end
    checks++; if (empty !== 1'b1 || ovf !== 1'b1) begin
      errors++; $display("FAIL drain got empty=%0b ovf=%0b exp empty=1 ovf=1", empty, ovf);
    end
    cycle(0, 0, 0, 1, 10'h000);
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL clr_ovf got=%0b exp=0", ovf); end
  endtask

  task automatic test_underflow();
    cycle(0, 1, 0, 0, 10'h000);
    checks++; if (unf !== 1'b1 || count !== 4'd0) begin
      errors++; $display("FAIL pop_empty got unf=%0b count=%0d exp unf=1 count=0", unf, count);
    end
    cycle(0, 0, 0, 1, 10'h000);
    checks++; if (unf !== 1'b0) begin errors++; $display("FAIL clr_unf got=%0b exp=0", unf); end
    cycle(0, 1, 0, 1, 10'h000);
    checks++; if (unf !== 1'b1) begin errors++; $display("FAIL clr_vs_set got=%0b exp=1", unf); end
    cycle(0, 0, 0, 1, 10'h000);
  endtask

  task automatic test_replace();
    cycle(1, 0, 0, 0, 10'h100);
    cycle(1, 0, 0, 0, 10'h200);
    cycle(1, 1, 0, 0, 10'h155);
    checks++; if (count !== 4'd2 || dout !== 10'h155 || unf !== 1'b0) begin
      errors++; $display("FAIL replace got count=%0d dout=%03h unf=%0b exp count=2 dout=155 unf=0", count, dout, unf);
    end
    cycle(0, 1, 0, 0, 10'h000);
    checks++; if (dout !== 10'h100) begin errors++; $display("FAIL replace_below got=%03h exp=100", dout); end
    cycle(0, 1, 0, 0, 10'h000);
    cycle(1, 1, 0, 0, 10'h0AB);
    checks++; if (count !== 4'd1 || dout !== 10'h0AB || unf !== 1'b1) begin
      errors++; $display("FAIL pushpop_empty got count=%0d dout=%03h unf=%0b exp count=1 dout=0AB unf=1", count, dout, unf);
    end
    cycle(0, 1, 0, 0, 10'h000);
  endtask

  task automatic test_flush();
    // unf is still set from the previous scenario; flush must leave it alone.
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 0, 10'h040 + 10'(i));
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL pre_flush got=%0d exp=5", count); end
    cycle(1, 0, 1, 0, 10'h3C3);
    checks++; if (count !== 4'd0 || dout !== 10'h000 || empty !== 1'b1) begin
      errors++; $display("FAIL flush got count=%0d dout=%03h empty=%0b exp count=0 dout=000 empty=1", count, dout, empty);
    end
    checks++; if (ovf !== 1'b0 || unf !== 1'b1) begin
      errors++; $display("FAIL flush_flags got ovf=%0b unf=%0b exp ovf=0 unf=1", ovf, unf);
    end
    cycle(0, 0, 0, 1, 10'h000);
  endtask

  task automatic test_async_reset();
    cycle(0, 1, 0, 0, 10'h000);
    cycle(1, 0, 0, 0, 10'h011);
    cycle(1, 0, 0, 0, 10'h022);
    cycle(1, 0, 0, 0, 10'h033);
    checks++; if (count !== 4'd3 || unf !== 1'b1) begin
      errors++; $display("FAIL pre_reset got count=%0d unf=%0b exp count=3 unf=1", count, unf);
    end
    #2 reset = 1'b1;
    #1;
    checks++; if (count !== 4'd0 || empty !== 1'b1 || dout !== 10'h000 || {ovf, unf} !== 2'b00) begin
      errors++; $display("FAIL async_reset got count=%0d empty=%0b dout=%03h flags=%02b exp 0/1/000/00",
                         count, empty, dout, {ovf, unf});
    end
    // Reset held across an edge must beat a concurrent push.
    push = 1'b1; din = 10'h3C0;
    @(posedge clk); #1;
    push = 1'b0;
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_over_push got=%0d exp=0", count); end
    reset = 1'b0;
    cycle(1, 0, 0, 0, 10'h077);
    checks++; if (count !== 4'd1 || dout !== 10'h077) begin
      errors++; $display("FAIL push_after_release got count=%0d dout=%03h exp count=1 dout=077", count, dout);
    end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_replace();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
